// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset level, zero word and
// the word-alignment helper used for redirect targets.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic             RstEnable = 1'b1;
  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem request, a one-entry stall
// buffer and a registered output stage feeding the IF/ID register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [InstAddrBus-1:0] redirect_addr_i,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [InstBus-1:0]     imem_data_i,
  output logic [InstAddrBus-1:0] if_addr_o,
  output logic [InstBus-1:0]     if_data_o,
  output logic                   if_valid_o,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Handshake: a request is open while imem_req_o=1; imem_addr_o stays
  // stable until the cycle imem_ack_i=1, which also carries imem_data_i.
  state_t                 state;
  logic [InstAddrBus-1:0] pc;
  logic [InstAddrBus-1:0] pend;
  logic [InstAddrBus-1:0] buf_addr;
  logic [InstBus-1:0]     buf_data;
  logic [InstAddrBus-1:0] target;

  assign target      = word_align(redirect_addr_i);
  assign imem_req_o  = (state == FETCH) || (state == FLUSH);
  assign imem_addr_o = pc;
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend       <= ZeroWord;
      buf_addr   <= ZeroWord;
      buf_data   <= ZeroWord;
      if_addr_o  <= ZeroWord;
      if_data_o  <= ZeroWord;
      if_valid_o <= 1'b0;
    end else begin
      // A redirect always squashes whatever would be presented next.
      if (redirect_i) begin
        if_valid_o <= 1'b0;
        if_data_o  <= ZeroWord;
      end
      case (state)
        IDLE: begin
          if (redirect_i) pc <= target;
          state <= FETCH;
        end
        FETCH: begin
          if (redirect_i) begin
            if (imem_ack_i) begin
              pc <= target;
            end else begin
              pend  <= target;
              state <= FLUSH;
            end
          end else if (imem_ack_i) begin
            pc <= pc + 32'd4;
            if (stall_i) begin
              buf_addr <= pc;
              buf_data <= imem_data_i;
              state    <= HOLD;
            end else begin
              if_addr_o  <= pc;
              if_data_o  <= imem_data_i;
              if_valid_o <= 1'b1;
            end
          end else if (!stall_i) begin
            if_valid_o <= 1'b0;
            if_data_o  <= ZeroWord;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc       <= target;
            buf_addr <= ZeroWord;
            buf_data <= ZeroWord;
            state    <= FETCH;
          end else if (!stall_i) begin
            if_addr_o  <= buf_addr;
            if_data_o  <= buf_data;
            if_valid_o <= 1'b1;
            state      <= FETCH;
          end
        end
        FLUSH: begin
          // The word in flight belongs to the squashed path; only its ack matters.
          if (redirect_i) pend <= target;
          if (imem_ack_i) begin
            pc    <= redirect_i ? target : pend;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios then random traffic,
// with a reference model and an in-order queue of expected presented words.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2, M_FLUSH = 3;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] if_addr_o;
  logic [31:0] if_data_o;
  logic        if_valid_o;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_live = 0;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_addr_i(redirect_addr_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .if_addr_o(if_addr_o), .if_data_o(if_data_o), .if_valid_o(if_valid_o),
    .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h0000_0013;
  endfunction

  assign imem_data_i = mem_word(imem_addr_o);

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance the model.
  task automatic drive(input logic r, input logic a, input logic s, input logic d,
                       input logic [31:0] t);
    logic [31:0] tgt;
    logic [63:0] e;
    rst = r; imem_ack_i = a; stall_i = s; redirect_i = d; redirect_addr_i = t;
    tgt = {t[31:2], 2'b00};
    @(negedge clk);
    if (m_live) begin
      check32("req", {31'b0, imem_req_o},
              {31'b0, (m_state == M_FETCH) || (m_state == M_FLUSH)});
      if ((m_state == M_FETCH) || (m_state == M_FLUSH))
        check32("req_addr", imem_addr_o, m_pc);
      if (!if_valid_o) begin
        check32("bubble_data", if_data_o, 32'h0);
      end else if (!s) begin
        check32("out_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check32("out_addr", if_addr_o, e[63:32]);
          check32("out_data", if_data_o, e[31:0]);
        end
      end
    end
    if (r) begin
      m_live = 1; m_state = M_IDLE; m_pc = RESET_PC; m_pend = 32'h0;
      exp_q.delete();
    end else if (m_live) begin
      case (m_state)
        M_IDLE: begin
          if (d) m_pc = tgt;
          m_state = M_FETCH;
        end
        M_FETCH: begin
          if (d) begin
            exp_q.delete();
            if (a) m_pc = tgt;
            else begin m_pend = tgt; m_state = M_FLUSH; end
          end else if (a) begin
            exp_q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
            if (s) m_state = M_HOLD;
          end
        end
        M_HOLD: begin
          if (d) begin exp_q.delete(); m_pc = tgt; m_state = M_FETCH; end
          else if (!s) m_state = M_FETCH;
        end
        default: begin
          if (d) m_pend = tgt;
          if (a) begin m_pc = d ? tgt : m_pend; m_state = M_FETCH; end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = 32'h0; imem_ack_i = 1'b0;

    // Reset state
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 32'h0000_0500);
    check32("rst_if_addr", if_addr_o, 32'h0);
    check32("rst_if_data", if_data_o, 32'h0);
    check32("rst_if_valid", {31'b0, if_valid_o}, 32'd0);
    check32("rst_req", {31'b0, imem_req_o}, 32'd0);

    // Streaming with single-cycle acks: 0,4,8,c
    drive(0, 0, 0, 0, 0);
    check32("first_req_addr", imem_addr_o, RESET_PC);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
    check32("stream_last_addr", if_addr_o, 32'h0000_000C);
    check32("stream_last_valid", {31'b0, if_valid_o}, 32'd1);

    // Ack at 0x10 under a three-cycle stall
    drive(0, 1, 1, 0, 0);
    check32("hold_req", {31'b0, imem_req_o}, 32'd0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    check32("hold_frozen_addr", if_addr_o, 32'h0000_000C);
    check32("hold_frozen_valid", {31'b0, if_valid_o}, 32'd1);
    drive(0, 0, 0, 0, 0);
    check32("release_addr", if_addr_o, 32'h0000_0010);
    check32("release_valid", {31'b0, if_valid_o}, 32'd1);
    check32("release_next_req", imem_addr_o, 32'h0000_0014);

    // Redirect while 0x20 is outstanding
    drive(0, 1, 0, 1, 32'h0000_0020);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h0000_0103);
    check32("flush_addr_stable", imem_addr_o, 32'h0000_0020);
    drive(0, 1, 0, 0, 0);
    check32("flush_next_req", imem_addr_o, 32'h0000_0100);
    check32("flush_no_valid", {31'b0, if_valid_o}, 32'd0);

    // Pending target overwritten in FLUSH, with and without a coincident ack
    drive(0, 0, 0, 1, 32'h0000_0300);
    drive(0, 0, 0, 1, 32'h0000_0404);
    drive(0, 1, 0, 1, 32'h0000_0508);
    check32("flush_ack_redirect", imem_addr_o, 32'h0000_0508);
    drive(0, 0, 0, 1, 32'h0000_0600);
    drive(0, 0, 0, 1, 32'h0000_0705);
    drive(0, 1, 0, 0, 0);
    check32("flush_overwrite", imem_addr_o, 32'h0000_0704);

    // Redirect coincident with ack and stall
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 32'h0000_0200);
    check32("redir_stall_valid", {31'b0, if_valid_o}, 32'd0);
    check32("redir_stall_data", if_data_o, 32'h0);
    check32("redir_stall_req", imem_addr_o, 32'h0000_0200);

    // pc wrap
    drive(0, 1, 0, 1, 32'hFFFF_FFFE);
    drive(0, 1, 0, 0, 0);
    check32("wrap_req", imem_addr_o, 32'h0000_0000);
    check32("wrap_out_addr", if_addr_o, 32'hFFFF_FFFC);

    // Reset mid-request, stray ack in IDLE
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 32'h0000_0800);
    drive(0, 1, 0, 0, 0);
    check32("rst_ack_ignored", {31'b0, if_valid_o}, 32'd0);
    check32("rst_restart_req", imem_addr_o, RESET_PC);
    drive(0, 1, 0, 0, 0);
    check32("rst_restart_out", if_addr_o, RESET_PC);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(0, imem_req_o && ($urandom_range(0, 3) != 0), $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom);
    end

    // Drain and confirm nothing expected was lost
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
    check32("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
